// File: rtl/sys_ctrl_burst.sv
// Command sequencer between a UART byte stream, the register file, the ALU and the TX FIFO.
// Handles single and burst register access, and ALU operations whose result goes back out over TX.
module sys_ctrl_burst #(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 4,
    parameter int ALU_WIDTH  = 16,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  FIFO_FULL,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    input  logic [ALU_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    output logic [ADD_WIDTH-1:0]  Address,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic                  ALU_EN,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  CLK_EN,
    output logic [DATA_WIDTH-1:0] TX_P_Data,
    output logic                  TX_D_VLD,
    output logic                  clk_div_en,
    output logic                  CMD_ERR,
    output logic [3:0]            dbg_state
);

    localparam int NB = ALU_WIDTH / DATA_WIDTH;
    localparam int CW = ADD_WIDTH + 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);
    localparam logic [DATA_WIDTH-1:0] CMD_BWR     = DATA_WIDTH'(8'hEE);
    localparam logic [DATA_WIDTH-1:0] CMD_BRD     = DATA_WIDTH'(8'hEF);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_CNT, GET_DATA, RD_REQ, RD_WAIT,
        TX_BYTE, GET_OPA, GET_OPB, GET_FUN, ALU_WAIT, ALU_TX
    } state_t;

    state_t                state;
    logic                  cmd_rd;
    logic                  cmd_burst;
    logic [ADD_WIDTH-1:0]  ptr;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] rd_byte;
    logic [ALU_WIDTH-1:0]  alu_res;
    logic [BW-1:0]         byte_idx;

    assign dbg_state = state;

    // RX_D_VLD, RdData_Valid and ALU_OUT_VLD are one-cycle strobes sampled only in the states
    // that wait for them; TX_D_VLD is issued only on a cycle where FIFO_FULL was seen low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            cmd_rd     <= 1'b0;
            cmd_burst  <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
            rd_byte    <= '0;
            alu_res    <= '0;
            byte_idx   <= '0;
            Address    <= '0;
            WrEn       <= 1'b0;
            RdEn       <= 1'b0;
            WrData     <= '0;
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            CLK_EN     <= 1'b0;
            TX_P_Data  <= '0;
            TX_D_VLD   <= 1'b0;
            clk_div_en <= 1'b0;
            CMD_ERR    <= 1'b0;
        end else begin
            WrEn       <= 1'b0;
            RdEn       <= 1'b0;
            ALU_EN     <= 1'b0;
            TX_D_VLD   <= 1'b0;
            CMD_ERR    <= 1'b0;
            clk_div_en <= 1'b1;
            case (state)
                IDLE: if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:      begin cmd_rd <= 1'b0; cmd_burst <= 1'b0; state <= GET_ADDR; end
                        CMD_RD:      begin cmd_rd <= 1'b1; cmd_burst <= 1'b0; state <= GET_ADDR; end
                        CMD_BWR:     begin cmd_rd <= 1'b0; cmd_burst <= 1'b1; state <= GET_ADDR; end
                        CMD_BRD:     begin cmd_rd <= 1'b1; cmd_burst <= 1'b1; state <= GET_ADDR; end
                        CMD_ALU_OP:  state <= GET_OPA;
                        CMD_ALU_NOP: state <= GET_FUN;
                        default:     CMD_ERR <= 1'b1;
                    endcase
                end
                // Single accesses reuse the burst path with a count of one.
                GET_ADDR: if (RX_D_VLD) begin
                    ptr <= RX_P_DATA[ADD_WIDTH-1:0];
                    cnt <= CW'(1);
                    if (cmd_burst)   state <= GET_CNT;
                    else if (cmd_rd) state <= RD_REQ;
                    else             state <= GET_DATA;
                end
                GET_CNT: if (RX_D_VLD) begin
                    cnt <= RX_P_DATA[CW-1:0];
                    if (RX_P_DATA[CW-1:0] == '0) state <= IDLE;
                    else if (cmd_rd)             state <= RD_REQ;
                    else                         state <= GET_DATA;
                end
                GET_DATA: if (RX_D_VLD) begin
                    WrEn    <= 1'b1;
                    Address <= ptr;
                    WrData  <= RX_P_DATA;
                    ptr     <= ptr + 1'b1;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= IDLE;
                end
                RD_REQ: begin
                    RdEn    <= 1'b1;
                    Address <= ptr;
                    ptr     <= ptr + 1'b1;
                    state   <= RD_WAIT;
                end
                RD_WAIT: if (RdData_Valid) begin
                    rd_byte <= RdData;
                    state   <= TX_BYTE;
                end
                TX_BYTE: if (!FIFO_FULL) begin
                    TX_D_VLD  <= 1'b1;
                    TX_P_Data <= rd_byte;
                    cnt       <= cnt - 1'b1;
                    state     <= (cnt == CW'(1)) ? IDLE : RD_REQ;
                end
                GET_OPA: if (RX_D_VLD) begin
                    WrEn    <= 1'b1;
                    Address <= '0;
                    WrData  <= RX_P_DATA;
                    state   <= GET_OPB;
                end
                GET_OPB: if (RX_D_VLD) begin
                    WrEn    <= 1'b1;
                    Address <= ADD_WIDTH'(1);
                    WrData  <= RX_P_DATA;
                    state   <= GET_FUN;
                end
                GET_FUN: if (RX_D_VLD) begin
                    ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                    ALU_EN  <= 1'b1;
                    CLK_EN  <= 1'b1;
                    state   <= ALU_WAIT;
                end
                ALU_WAIT: if (ALU_OUT_VLD) begin
                    alu_res  <= ALU_OUT;
                    CLK_EN   <= 1'b0;
                    byte_idx <= '0;
                    state    <= ALU_TX;
                end
                // Result leaves least significant byte first by shifting it down.
                ALU_TX: if (!FIFO_FULL) begin
                    TX_D_VLD  <= 1'b1;
                    TX_P_Data <= alu_res[DATA_WIDTH-1:0];
                    alu_res   <= alu_res >> DATA_WIDTH;
                    byte_idx  <= byte_idx + 1'b1;
                    if (byte_idx == BW'(NB - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Bench for sys_ctrl_burst: directed scenarios then random commands, scored against a command-level model.
// The bench also plays register file, ALU and TX FIFO around the DUT.
module tb_sys_ctrl_burst;
    localparam int DW = 8, AW = 4, ALW = 16, FW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] RX_P_DATA = '0;
    logic          RX_D_VLD = 1'b0;
    logic          FIFO_FULL = 1'b0;
    logic [DW-1:0] RdData = '0;
    logic          RdData_Valid = 1'b0;
    logic [ALW-1:0] ALU_OUT = '0;
    logic          ALU_OUT_VLD = 1'b0;
    logic [AW-1:0] Address;
    logic          WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, clk_div_en, CMD_ERR;
    logic [DW-1:0] WrData, TX_P_Data;
    logic [FW-1:0] ALU_FUN;
    logic [3:0]    dbg_state;

    always #5 CLK = ~CLK;

    sys_ctrl_burst #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .ALU_WIDTH(ALW), .FUN_WIDTH(FW)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .FIFO_FULL(FIFO_FULL),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData), .ALU_EN(ALU_EN),
        .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN), .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD),
        .clk_div_en(clk_div_en), .CMD_ERR(CMD_ERR), .dbg_state(dbg_state)
    );

    // Scoreboard queues and model state
    logic [11:0]   wr_q[$];
    logic [DW-1:0] tx_q[$];
    logic [FW-1:0] fun_q[$];
    logic [15:0]   alu_q[$];
    logic [DW-1:0] cmd_bytes[$];
    logic [DW-1:0] ref_mem[16];
    logic [DW-1:0] rf[16];

    int n_checks = 0, n_errors = 0;
    int err_exp = 0, err_seen = 0, both_hi = 0;
    int ev_wr = 0, ev_rd = 0, ev_tx = 0, cyc = 0;
    int rden_cyc = 0, tx_cyc = 0;
    int rd_dly = 0, alu_dly = 0, full_cnt = 0;
    bit rd_pend = 0, alu_pend = 0, full_rand = 0, rd_rand = 0, full_arm = 0;
    logic [AW-1:0]  rd_addr = '0;
    logic [15:0]    alu_val_r = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Environment: register file, ALU and FIFO responders plus output monitor
    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            rd_pend = 0; alu_pend = 0; full_cnt = 0;
            RdData_Valid = 1'b0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
        end else begin
            if (full_arm && RdData_Valid) begin full_cnt = 4; full_arm = 0; end
            if (full_cnt > 0) begin FIFO_FULL = 1'b1; full_cnt--; end
            else FIFO_FULL = full_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (WrEn && RdEn) both_hi++;
            if (WrEn) begin
                ev_wr++;
                rf[Address] = WrData;
                if (wr_q.size() > 0) check_eq("wr", 32'({Address, WrData}), 32'(wr_q.pop_front()));
                else check_eq("wr_expected", 32'(wr_q.size()), 1);
            end
            if (RdEn) begin
                ev_rd++;
                rd_pend = 1; rd_addr = Address; rden_cyc = cyc;
                rd_dly = rd_rand ? $urandom_range(0, 2) : 0;
            end
            if (ALU_EN) begin
                check_eq("clk_en_at_alu_en", 32'(CLK_EN), 1);
                if (fun_q.size() > 0) check_eq("alu_fun", 32'(ALU_FUN), 32'(fun_q.pop_front()));
                else check_eq("alu_expected", 32'(fun_q.size()), 1);
                alu_val_r = (alu_q.size() > 0) ? alu_q.pop_front() : 16'hDEAD;
                alu_pend = 1;
                alu_dly = rd_rand ? $urandom_range(0, 3) : 1;
            end
            if (TX_D_VLD) begin
                ev_tx++; tx_cyc = cyc;
                if (tx_q.size() > 0) check_eq("tx", 32'(TX_P_Data), 32'(tx_q.pop_front()));
                else check_eq("tx_expected", 32'(tx_q.size()), 1);
            end
            if (CMD_ERR) err_seen++;
            RdData_Valid = 1'b0;
            if (rd_pend) begin
                if (rd_dly == 0) begin RdData = rf[rd_addr]; RdData_Valid = 1'b1; rd_pend = 0; end
                else rd_dly--;
            end
            ALU_OUT_VLD = 1'b0;
            if (alu_pend) begin
                if (alu_dly == 0) begin ALU_OUT = alu_val_r; ALU_OUT_VLD = 1'b1; alu_pend = 0; end
                else alu_dly--;
            end
        end
    end

    // Command-level reference: what each command must do to the register file and TX stream
    task automatic model_cmd(input logic [15:0] alu_val);
        logic [7:0] c, b;
        logic [3:0] ad;
        int a, n;
        c = cmd_bytes[0];
        case (c)
            8'hAA: begin
                ad = 4'(cmd_bytes[1]); b = cmd_bytes[2];
                ref_mem[ad] = b; wr_q.push_back({ad, b});
            end
            8'hBB: begin ad = 4'(cmd_bytes[1]); tx_q.push_back(ref_mem[ad]); end
            8'hEE, 8'hEF: begin
                a = int'(cmd_bytes[1]) % 16;
                n = int'(cmd_bytes[2]) % 32;
                for (int i = 0; i < n; i++) begin
                    ad = 4'((a + i) % 16);
                    if (c == 8'hEE) begin
                        b = cmd_bytes[3 + i];
                        ref_mem[ad] = b; wr_q.push_back({ad, b});
                    end else tx_q.push_back(ref_mem[ad]);
                end
            end
            8'hCC, 8'hDD: begin
                if (c == 8'hCC) begin
                    b = cmd_bytes[1]; ref_mem[0] = b; wr_q.push_back({4'd0, b});
                    b = cmd_bytes[2]; ref_mem[1] = b; wr_q.push_back({4'd1, b});
                    b = cmd_bytes[3];
                end else b = cmd_bytes[1];
                fun_q.push_back(b[3:0]);
                alu_q.push_back(alu_val);
                tx_q.push_back(alu_val[7:0]);
                tx_q.push_back(alu_val[15:8]);
            end
            default: err_exp++;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        RX_P_DATA = b; RX_D_VLD = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD = 1'b0;
        repeat (gap) begin @(posedge CLK); #1; end
    endtask

    task automatic drain();
        int t = 0;
        while ((wr_q.size() > 0 || tx_q.size() > 0 || rd_pend || alu_pend || alu_q.size() > 0) && t < 3000) begin
            @(posedge CLK); t++;
        end
        check_eq("drain_timeout", 32'(t >= 3000), 0);
        repeat (4) @(posedge CLK);
        #1;
        check_eq("cmd_err_count", 32'(err_seen), 32'(err_exp));
        check_eq("clk_en_idle", 32'(CLK_EN), 0);
    endtask

    task automatic run_cmd(input logic [15:0] alu_val, input int max_gap);
        model_cmd(alu_val);
        foreach (cmd_bytes[i]) send_byte(cmd_bytes[i], $urandom_range(0, max_gap));
        drain();
    endtask

    task automatic gen_cmd();
        int k, n;
        logic [7:0] b;
        cmd_bytes.delete();
        k = $urandom_range(0, 6);
        case (k)
            0: begin cmd_bytes.push_back(8'hAA); cmd_bytes.push_back(8'($urandom)); cmd_bytes.push_back(8'($urandom)); end
            1: begin cmd_bytes.push_back(8'hBB); cmd_bytes.push_back(8'($urandom)); end
            2, 3: begin
                n = $urandom_range(0, 20);
                cmd_bytes.push_back(k == 2 ? 8'hEE : 8'hEF);
                cmd_bytes.push_back(8'($urandom));
                cmd_bytes.push_back(8'(($urandom_range(0, 7) << 5) | n));
                if (k == 2) for (int i = 0; i < n; i++) cmd_bytes.push_back(8'($urandom));
            end
            4: begin
                cmd_bytes.push_back(8'hCC);
                for (int i = 0; i < 3; i++) cmd_bytes.push_back(8'($urandom));
            end
            5: begin cmd_bytes.push_back(8'hDD); cmd_bytes.push_back(8'($urandom)); end
            default: begin
                do b = 8'($urandom);
                while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD || b == 8'hEE || b == 8'hEF);
                cmd_bytes.push_back(b);
            end
        endcase
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({WrEn, RdEn, TX_D_VLD, ALU_EN, CMD_ERR, CLK_EN, clk_div_en,
                    Address, WrData, ALU_FUN, TX_P_Data});
    endfunction

    initial begin
        int lat0, lat1, t, b_wr, b_rd, b_tx;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'($urandom);
            rf[i] = ref_mem[i];
        end
        repeat (2) @(posedge CLK);
        #1;
        check_eq("reset_outputs", out_vec(), 0);
        @(negedge CLK); #2;
        RST = 1'b1;
        @(posedge CLK); #1;
        check_eq("clk_div_en_after_reset", 32'(clk_div_en), 1);

        // Single write, no TX
        cmd_bytes = {8'hAA, 8'h05, 8'h3C};
        run_cmd(16'h0, 0);

        // Single read, then the same read with the FIFO full for 4 cycles
        cmd_bytes = {8'hAA, 8'h02, 8'h7E};
        run_cmd(16'h0, 0);
        cmd_bytes = {8'hBB, 8'h02};
        run_cmd(16'h0, 0);
        lat0 = tx_cyc - rden_cyc;
        full_arm = 1;
        cmd_bytes = {8'hBB, 8'h02};
        b_tx = ev_tx;
        run_cmd(16'h0, 0);
        lat1 = tx_cyc - rden_cyc;
        check_eq("read_tx_once", 32'(ev_tx - b_tx), 1);
        check_eq("fifo_full_delay", 32'(lat1 - lat0), 4);

        // Burst write wrapping past the top of the address space
        cmd_bytes = {8'hEE, 8'h0E, 8'h03, 8'h11, 8'h22, 8'h33};
        run_cmd(16'h0, 1);

        // Burst read with a stray byte arriving while the read is in flight
        cmd_bytes = {8'hEF, 8'h0E, 8'h03};
        model_cmd(16'h0);
        send_byte(8'hEF, 0); send_byte(8'h0E, 0); send_byte(8'h03, 0);
        send_byte(8'hAA, 0);
        drain();

        // Zero-length bursts
        cmd_bytes = {8'hEE, 8'h04, 8'h00};
        run_cmd(16'h0, 0);
        cmd_bytes = {8'hEF, 8'h09, 8'hE0};
        run_cmd(16'h0, 0);

        // ALU with operands
        cmd_bytes = {8'hCC, 8'h0A, 8'h14, 8'h00};
        run_cmd(16'h001E, 0);

        // Illegal command followed by a normal write
        cmd_bytes = {8'h55};
        run_cmd(16'h0, 0);
        cmd_bytes = {8'hAA, 8'h07, 8'h99};
        run_cmd(16'h0, 0);

        // Random command stream with random FIFO back-pressure and response latency
        full_rand = 1; rd_rand = 1;
        for (int i = 0; i < 40; i++) begin
            gen_cmd();
            run_cmd(16'($urandom), 2);
        end
        full_rand = 0; rd_rand = 0;

        // Reset in the middle of a 3-element burst read
        cmd_bytes = {8'hEF, 8'h03, 8'h03};
        model_cmd(16'h0);
        b_tx = ev_tx;
        foreach (cmd_bytes[i]) send_byte(cmd_bytes[i], 0);
        t = 0;
        while (ev_tx == b_tx && t < 200) begin @(posedge CLK); t++; end
        check_eq("rst_first_tx_seen", 32'(ev_tx - b_tx), 1);
        #1;
        RST = 1'b0;
        #1;
        check_eq("rst_mid_outputs", out_vec(), 0);
        tx_q.delete(); wr_q.delete();
        repeat (3) @(negedge CLK);
        #2;
        RST = 1'b1;
        b_wr = ev_wr; b_rd = ev_rd; b_tx = ev_tx;
        repeat (30) @(posedge CLK);
        #1;
        check_eq("rst_no_rden", 32'(ev_rd - b_rd), 0);
        check_eq("rst_no_tx", 32'(ev_tx - b_tx), 0);
        check_eq("rst_no_wren", 32'(ev_wr - b_wr), 0);
        check_eq("clk_div_en_after_rerelease", 32'(clk_div_en), 1);

        // Normal operation resumes after the abort
        cmd_bytes = {8'hBB, 8'h04};
        run_cmd(16'h0, 0);

        check_eq("wren_rden_overlap", 32'(both_hi), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_burst.md
SYS_CTRL_BURST -- requirements
Module: sys_ctrl_burst

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width of RX, TX and register data.
REQ-002 Parameter ADD_WIDTH, default 4, register-file address width; address space is 2^ADD_WIDTH.
REQ-003 Parameter ALU_WIDTH, default 16, ALU result width; SHALL be an integer multiple of DATA_WIDTH. NB = ALU_WIDTH/DATA_WIDTH.
REQ-004 Parameter FUN_WIDTH, default 4, ALU function code width.
REQ-005 CLK  in  1  single clock; all logic rising-edge.
REQ-006 RST  in  1  asynchronous, active-low reset.
REQ-007 RX_P_DATA  in  DATA_WIDTH  received byte; RX_D_VLD  in  1  one-cycle strobe, byte valid.
REQ-008 FIFO_FULL  in  1  TX FIFO full; no TX_D_VLD while high.
REQ-009 RdData  in  DATA_WIDTH, RdData_Valid  in  1  register read return.
REQ-010 ALU_OUT  in  ALU_WIDTH, ALU_OUT_VLD  in  1  ALU result strobe.
REQ-011 Address  out  ADD_WIDTH; WrEn  out  1; RdEn  out  1; WrData  out  DATA_WIDTH.
REQ-012 ALU_EN  out  1; ALU_FUN  out  FUN_WIDTH; CLK_EN  out  1  ALU clock-gate enable.
REQ-013 TX_P_Data  out  DATA_WIDTH; TX_D_VLD  out  1  one-cycle FIFO write strobe.
REQ-014 clk_div_en  out  1  clock-divider enable; CMD_ERR  out  1  one-cycle illegal-command pulse.

Function
REQ-015 Commands (first byte): 0xAA write (ADDR, DATA); 0xBB read (ADDR); 0xCC ALU with operands (A, B, FUN); 0xDD ALU no operands (FUN); 0xEE burst write (ADDR, N, N data bytes); 0xEF burst read (ADDR, N).
REQ-016 States: IDLE, GET_ADDR, GET_CNT, GET_DATA, RD_REQ, RD_WAIT, TX_BYTE, GET_OPA, GET_OPB, GET_FUN, ALU_WAIT, ALU_TX.
REQ-017 Every state advances only on a cycle with RX_D_VLD=1, except RD_REQ, RD_WAIT, TX_BYTE, ALU_WAIT, ALU_TX.
REQ-018 IDLE: byte not in REQ-015 -> CMD_ERR=1 next cycle, stay IDLE.
REQ-019 Write: WrEn=1 one cycle, the cycle after DATA is received, with Address=ADDR, WrData=DATA.
REQ-020 Read: RdEn=1 one cycle with Address; wait RdData_Valid; latch RdData; TX_BYTE.
REQ-021 TX_BYTE: if FIFO_FULL=0, TX_P_Data=byte, TX_D_VLD=1 one cycle; else hold, no byte dropped or duplicated.
REQ-022 Burst: N (low ADD_WIDTH+1 bits used) transfers at Address, Address+1, ...; address wraps modulo 2^ADD_WIDTH.
REQ-023 Burst write: one WrEn per received data byte; return to IDLE after Nth write.
REQ-024 Burst read: RdEn, RD_WAIT, TX_BYTE per element; next RdEn only after previous byte is pushed.
REQ-025 N=0: burst is a no-op; burst write expects no data bytes; return to IDLE immediately.
REQ-026 0xCC: A written to address 0, B to address 1 (WrEn pulse each), then GET_FUN.
REQ-027 On FUN: ALU_FUN latched, ALU_EN=1 one cycle, CLK_EN=1 from FUN receipt until ALU_OUT_VLD seen.
REQ-028 ALU_OUT latched on ALU_OUT_VLD; ALU_TX sends NB bytes, least significant first, each per REQ-021.
REQ-029 RX_D_VLD during a non-receiving state: byte ignored.
REQ-030 WrEn and RdEn never high in the same cycle; at most one TX_D_VLD per cycle.
REQ-031 clk_div_en SHALL be 1 at all times out of reset.

Reset
REQ-032 RST=0: state IDLE; all strobes, Address, WrData, ALU_FUN, TX_P_Data, CLK_EN, CMD_ERR = 0; clk_div_en = 0.
REQ-033 Reset mid-command aborts it; no pending write, read or TX completes after release.

Verification
REQ-034 RX AA,05,3C -> one WrEn with Address=5, WrData=0x3C; no TX.
REQ-035 RX BB,02, RdData=0x7E -> TX_D_VLD once, TX_P_Data=0x7E; FIFO_FULL held 4 cycles delays push exactly 4 cycles.
REQ-036 RX EE,0E,03,11,22,33 -> writes addr E=0x11, F=0x22, 0=0x33 (wrap).
REQ-037 RX CC,0A,14,00, ALU_OUT=0x001E -> writes addr0=0x0A, addr1=0x14; ALU_EN pulse ALU_FUN=0; TX 0x1E then 0x00.
REQ-038 RX 55 -> CMD_ERR one cycle, no other outputs; following AA command executes normally.
REQ-039 RST low during burst read after 1 of 3 bytes -> no further RdEn or TX; outputs at reset values.
